// File: rtl/ima_adpcm_pkg.sv
// Shared IMA ADPCM definitions: widths, state encoding, step-size and index-delta tables.
// Used by both the encoder and the decoder so their predictors stay bit-identical.
package ima_adpcm_pkg;

  localparam int SAMP_W    = 16;
  localparam int PRED_W    = 19;
  localparam int STEP_W    = 15;
  localparam int INDEX_W   = 7;
  localparam int MAX_INDEX = 88;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BIT2 = 3'd1,
    ST_BIT1 = 3'd2,
    ST_BIT0 = 3'd3,
    ST_DONE = 3'd4
  } adpcmState_t;

  localparam int STEP_TABLE [0:MAX_INDEX] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
    19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
    130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
    337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
    876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
    2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
    5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
    15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
  };

  localparam int INDEX_DELTA [0:7] = '{-1, -1, -1, -1, 2, 4, 6, 8};

  function automatic logic [STEP_W-1:0] stepLookup(input logic [INDEX_W-1:0] index);
    if (index > INDEX_W'(MAX_INDEX)) return STEP_W'(32767);
    return STEP_W'(STEP_TABLE[index]);
  endfunction

  // Round the 3-bit fraction away; the top code must not wrap to 0x8000.
  function automatic logic [SAMP_W-1:0] roundPred(input logic [PRED_W-1:0] pred);
    if (pred[PRED_W-1:3] == 16'h7FFF && pred[2]) return 16'h7FFF;
    return pred[PRED_W-1:3] + {15'b0, pred[2]};
  endfunction

endpackage

// File: rtl/ima_adpcm_dec_if.sv
// Code-stream input / PCM output bundle of the IMA ADPCM decoder.
interface ima_adpcm_dec_if;
  import ima_adpcm_pkg::*;

  logic [3:0]         inPCM;
  logic               inValid;
  logic               inInit;
  logic [SAMP_W-1:0]  inInitSamp;
  logic [INDEX_W-1:0] inInitIndex;
  logic               inReady;
  logic [SAMP_W-1:0]  outSamp;
  logic               outValid;
  logic [SAMP_W-1:0]  outPredictSamp;
  logic [INDEX_W-1:0] outStepIndex;

  modport slave (
    input  inPCM, inValid, inInit, inInitSamp, inInitIndex,
    output inReady, outSamp, outValid, outPredictSamp, outStepIndex
  );

  modport master (
    output inPCM, inValid, inInit, inInitSamp, inInitIndex,
    input  inReady, outSamp, outValid, outPredictSamp, outStepIndex
  );
endinterface

// File: rtl/ima_adpcm_step_rom.sv
// Registered step-index to step-size lookup, one cycle of latency.
module ima_adpcm_step_rom
  import ima_adpcm_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [INDEX_W-1:0] index,
  output logic [STEP_W-1:0]  stepSize
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) stepSize <= '0;
    else       stepSize <= stepLookup(index);
  end

endmodule

// File: rtl/ima_adpcm_dec.sv
// IMA ADPCM decoder: one 4-bit code in, one 16-bit PCM sample out every 5 cycles.
// state | meaning
// IDLE  | waiting for a code or a re-seed
// BIT2  | dq = step + bit2 * 8*step
// BIT1  | dq += bit1 * 4*step
// BIT0  | dq += bit0 * 2*step
// DONE  | apply dq to predictor with saturation, update step index
module ima_adpcm_dec
  import ima_adpcm_pkg::*;
#(
  parameter int unsigned RST_STEP_INDEX = 0
) (
  input logic            clock,
  input logic            reset,
  ima_adpcm_dec_if.slave bus
);

  localparam logic signed [PRED_W+1:0] PRED_MAX = (PRED_W+2)'(2**(PRED_W-1) - 1);
  localparam logic signed [PRED_W+1:0] PRED_MIN = -(PRED_W+2)'(2**(PRED_W-1));

  adpcmState_t state, stateNext;

  logic                      inReadyR;
  logic                      outValidR;
  logic                      pendOut;
  logic [SAMP_W-1:0]         outSampR;
  logic [3:0]                code;
  logic [PRED_W-1:0]         dq;
  logic signed [PRED_W-1:0]  predictor;
  logic signed [PRED_W-1:0]  predSat;
  logic [INDEX_W-1:0]        stepIndex;
  logic [INDEX_W-1:0]        indexNext;
  logic [INDEX_W-1:0]        seedIndex;
  logic [STEP_W-1:0]         stepSize;
  logic [PRED_W-1:0]         stepExt;
  logic signed [PRED_W+1:0]  predWide;
  logic signed [PRED_W+1:0]  dqWide;
  logic signed [PRED_W+1:0]  preSum;
  logic                      accept;
  logic                      seed;
  int                        idxSum;

  ima_adpcm_step_rom uStepRom (
    .clock    (clock),
    .reset    (reset),
    .index    (stepIndex),
    .stepSize (stepSize)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = ST_IDLE;
    accept    = (state == ST_IDLE) && inReadyR && bus.inValid && !bus.inInit;
    seed      = (state == ST_IDLE) && inReadyR && bus.inInit;
    case (state)
      ST_IDLE: stateNext = accept ? ST_BIT2 : ST_IDLE;
      ST_BIT2: stateNext = ST_BIT1;
      ST_BIT1: stateNext = ST_BIT0;
      ST_BIT0: stateNext = ST_DONE;
      ST_DONE: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  // One spare bit beyond the 20-bit sum so a full-scale dq cannot wrap past the rails.
  always_comb begin
    stepExt   = PRED_W'(stepSize);
    predWide  = {{2{predictor[PRED_W-1]}}, predictor};
    dqWide    = {2'b00, dq};
    preSum    = code[3] ? (predWide - dqWide) : (predWide + dqWide);
    predSat   = preSum[PRED_W-1:0];
    if (preSum > PRED_MAX)      predSat = PRED_MAX[PRED_W-1:0];
    else if (preSum < PRED_MIN) predSat = PRED_MIN[PRED_W-1:0];

    idxSum    = int'(stepIndex) + INDEX_DELTA[code[2:0]];
    if (idxSum < 0)         idxSum = 0;
    if (idxSum > MAX_INDEX) idxSum = MAX_INDEX;
    indexNext = INDEX_W'(idxSum);

    seedIndex = (bus.inInitIndex > INDEX_W'(MAX_INDEX)) ? INDEX_W'(MAX_INDEX) : bus.inInitIndex;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inReadyR  <= 1'b0;
      outValidR <= 1'b0;
      pendOut   <= 1'b0;
      outSampR  <= '0;
      code      <= '0;
      dq        <= '0;
      predictor <= '0;
      stepIndex <= INDEX_W'(RST_STEP_INDEX);
    end else begin
      outValidR <= pendOut;
      pendOut   <= (state == ST_DONE);
      if (pendOut) outSampR <= roundPred(predictor);
      case (state)
        ST_IDLE: begin
          inReadyR <= !accept;
          if (accept) code <= bus.inPCM;
          if (seed) begin
            predictor <= {bus.inInitSamp, 3'b000};
            stepIndex <= seedIndex;
          end
        end
        ST_BIT2: dq <= stepExt + (code[2] ? (stepExt << 3) : '0);
        ST_BIT1: if (code[1]) dq <= dq + (stepExt << 2);
        ST_BIT0: if (code[0]) dq <= dq + (stepExt << 1);
        ST_DONE: begin
          predictor <= predSat;
          stepIndex <= indexNext;
          inReadyR  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.inReady        = inReadyR;
  assign bus.outValid       = outValidR;
  assign bus.outSamp        = outSampR;
  assign bus.outPredictSamp = roundPred(predictor);
  assign bus.outStepIndex   = stepIndex;

endmodule

// File: tb/tb_ima_adpcm_dec.sv
// Self-checking bench for ima_adpcm_dec against an integer IMA reference model.
module tb_ima_adpcm_dec;

  localparam int STEP [0:88] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
    19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
    130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
    337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
    876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
    2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
    5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
    15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
  };

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  int   mPred = 0;
  int   mIdx = 0;

  ima_adpcm_dec_if bus ();

  ima_adpcm_dec #(.RST_STEP_INDEX(0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: predictor in 1/8 LSB units, dq = step * (2*magnitude + 1).
  function automatic logic [15:0] mRound(input int p);
    int s;
    s = (p >>> 3) + ((p >> 2) & 1);
    if (s > 32767) s = 32767;
    return 16'(s);
  endfunction

  function automatic logic [15:0] mDecode(input logic [3:0] c);
    int mag, dq;
    mag = int'(c[2:0]);
    dq  = STEP[mIdx] * (2 * mag + 1);
    mPred = c[3] ? mPred - dq : mPred + dq;
    if (mPred > 262143)  mPred = 262143;
    if (mPred < -262144) mPred = -262144;
    mIdx = mIdx + ((mag < 4) ? -1 : 2 * (mag - 3));
    if (mIdx < 0)  mIdx = 0;
    if (mIdx > 88) mIdx = 88;
    return mRound(mPred);
  endfunction

  function automatic void mSeed(input logic [15:0] s, input int idx);
    mPred = int'($signed(s)) * 8;
    mIdx  = (idx > 88) ? 88 : idx;
  endfunction

  task automatic applyReset();
    reset = 1'b1;
    bus.inValid = 1'b0;
    bus.inInit = 1'b0;
    bus.inPCM = 4'h0;
    bus.inInitSamp = 16'h0;
    bus.inInitIndex = 7'h0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    mPred = 0;
    mIdx = 0;
  endtask

  task automatic waitReady(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.inReady === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Offers one code and reports the sample and accept-to-outValid latency (-1 on timeout).
  task automatic runCode(input logic [3:0] c, output logic [15:0] samp, output int lat);
    bit ok;
    lat = -1;
    samp = 16'hxxxx;
    waitReady(ok);
    if (!ok) return;
    bus.inPCM = c;
    bus.inValid = 1'b1;
    @(posedge clock);
    #1;
    bus.inValid = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clock);
      #1;
      if (bus.outValid === 1'b1) begin
        lat = i;
        samp = bus.outSamp;
        break;
      end
    end
  endtask

  task automatic doSeed(input logic [15:0] s, input logic [6:0] idx);
    bit ok;
    waitReady(ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL seed_ready: got inReady=%b required 1", bus.inReady);
    end
    bus.inInit = 1'b1;
    bus.inInitSamp = s;
    bus.inInitIndex = idx;
    @(posedge clock);
    #1;
    bus.inInit = 1'b0;
    mSeed(s, int'(idx));
  endtask

  task automatic test_reset();
    bit ok;
    reset = 1'b1;
    bus.inValid = 1'b0;
    bus.inInit = 1'b0;
    bus.inPCM = 4'h0;
    bus.inInitSamp = 16'h0;
    bus.inInitIndex = 7'h0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    compared++;
    if ({bus.inReady, bus.outValid} !== 2'b00) begin
      mismatched++;
      $display("FAIL reset_flags: got ready=%b valid=%b required 0 0", bus.inReady, bus.outValid);
    end
    compared++;
    if (bus.outSamp !== 16'h0 || bus.outPredictSamp !== 16'h0) begin
      mismatched++;
      $display("FAIL reset_samp: got samp=%h pred=%h required 0000 0000", bus.outSamp, bus.outPredictSamp);
    end
    compared++;
    if (bus.outStepIndex !== 7'd0) begin
      mismatched++;
      $display("FAIL reset_index: got %0d required 0", bus.outStepIndex);
    end
    reset = 1'b0;
    #1;
    compared++;
    if (bus.inReady !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_ready_reg: got %b required 0 before first edge", bus.inReady);
    end
    waitReady(ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL reset_ready_rise: inReady never rose, required 1");
    end
  endtask

  task automatic test_basic();
    logic [15:0] samp;
    int lat;
    logic [15:0] e;
    applyReset();
    e = mDecode(4'h0);
    runCode(4'h0, samp, lat);
    compared++;
    if (lat !== 5) begin
      mismatched++;
      $display("FAIL latency: got %0d required 5", lat);
    end
    compared++;
    if (samp !== 16'h0001 || samp !== e) begin
      mismatched++;
      $display("FAIL code0_samp: got %h required 0001", samp);
    end
    compared++;
    if (bus.outStepIndex !== 7'd0 || bus.outPredictSamp !== 16'h0001) begin
      mismatched++;
      $display("FAIL code0_state: got idx=%0d pred=%h required 0 0001", bus.outStepIndex, bus.outPredictSamp);
    end
    @(posedge clock);
    #1;
    compared++;
    if (bus.outValid !== 1'b0) begin
      mismatched++;
      $display("FAIL valid_pulse: got outValid=%b one cycle later, required 0", bus.outValid);
    end

    applyReset();
    e = mDecode(4'h7);
    runCode(4'h7, samp, lat);
    compared++;
    if (samp !== 16'h000D || samp !== e || bus.outStepIndex !== 7'd8) begin
      mismatched++;
      $display("FAIL code7: got samp=%h idx=%0d required 000d 8", samp, bus.outStepIndex);
    end
    e = mDecode(4'h0);
    runCode(4'h0, samp, lat);
    compared++;
    if (samp !== 16'h000F || samp !== e) begin
      mismatched++;
      $display("FAIL step16: got samp=%h required 000f", samp);
    end

    applyReset();
    e = mDecode(4'hF);
    runCode(4'hF, samp, lat);
    compared++;
    if (samp !== 16'hFFF3 || samp !== e || bus.outStepIndex !== 7'd8) begin
      mismatched++;
      $display("FAIL codeF: got samp=%h idx=%0d required fff3 8", samp, bus.outStepIndex);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] samp;
    int lat;
    applyReset();
    doSeed(16'h7FFF, 7'd88);
    runCode(4'h7, samp, lat);
    compared++;
    if (samp !== 16'h7FFF || bus.outPredictSamp !== 16'h7FFF || bus.outStepIndex !== 7'd88) begin
      mismatched++;
      $display("FAIL sat_pos: got samp=%h pred=%h idx=%0d required 7fff 7fff 88", samp, bus.outPredictSamp, bus.outStepIndex);
    end
    doSeed(16'h8000, 7'd88);
    runCode(4'hF, samp, lat);
    compared++;
    if (samp !== 16'h8000 || bus.outPredictSamp !== 16'h8000 || bus.outStepIndex !== 7'd88) begin
      mismatched++;
      $display("FAIL sat_neg: got samp=%h pred=%h idx=%0d required 8000 8000 88", samp, bus.outPredictSamp, bus.outStepIndex);
    end
    doSeed(16'h0123, 7'd120);
    compared++;
    if (bus.outStepIndex !== 7'd88 || bus.outPredictSamp !== 16'h0123) begin
      mismatched++;
      $display("FAIL seed_clamp: got idx=%0d pred=%h required 88 0123", bus.outStepIndex, bus.outPredictSamp);
    end
  endtask

  task automatic test_init_priority();
    logic [15:0] samp;
    logic [15:0] e;
    int lat;
    bit ok;
    applyReset();
    waitReady(ok);
    bus.inInit = 1'b1;
    bus.inInitSamp = 16'h1234;
    bus.inInitIndex = 7'd10;
    bus.inPCM = 4'h7;
    bus.inValid = 1'b1;
    @(posedge clock);
    #1;
    bus.inInit = 1'b0;
    mSeed(16'h1234, 10);
    compared++;
    if (bus.outStepIndex !== 7'd10 || bus.outPredictSamp !== 16'h1234) begin
      mismatched++;
      $display("FAIL prio_seed: got idx=%0d pred=%h required 10 1234", bus.outStepIndex, bus.outPredictSamp);
    end
    compared++;
    if (bus.inReady !== 1'b1 || bus.outValid !== 1'b0) begin
      mismatched++;
      $display("FAIL prio_ready: got ready=%b valid=%b required 1 0", bus.inReady, bus.outValid);
    end
    e = mDecode(4'h7);
    runCode(4'h7, samp, lat);
    compared++;
    if (samp !== e || lat !== 5) begin
      mismatched++;
      $display("FAIL prio_pending: got samp=%h lat=%0d required %h 5", samp, lat, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  codes [10];
    logic [15:0] exp [10];
    int          acc [10];
    int          seen;
    bit          ok;
    applyReset();
    for (int i = 0; i < 10; i++) begin
      codes[i] = 4'($urandom_range(0, 15));
      exp[i] = mDecode(codes[i]);
    end
    seen = 0;
    fork
      begin
        bus.inValid = 1'b1;
        for (int i = 0; i < 10; i++) begin
          bus.inPCM = codes[i];
          ok = 1'b0;
          for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clock);
            if (bus.inReady === 1'b1) ok = 1'b1;
          end
          @(posedge clock);
          #1;
          acc[i] = cyc;
        end
        bus.inValid = 1'b0;
      end
      begin
        for (int t = 0; t < 80; t++) begin
          @(posedge clock);
          #1;
          if (bus.outValid === 1'b1) begin
            compared++;
            if (seen >= 10) begin
              mismatched++;
              $display("FAIL b2b_extra: got outValid pulse %0d required at most 10", seen + 1);
            end else if (bus.outSamp !== exp[seen]) begin
              mismatched++;
              $display("FAIL b2b_samp[%0d]: got %h required %h", seen, bus.outSamp, exp[seen]);
            end
            seen++;
          end
        end
      end
    join
    compared++;
    if (seen != 10) begin
      mismatched++;
      $display("FAIL b2b_count: got %0d outputs required 10", seen);
    end
    for (int i = 1; i < 10; i++) begin
      compared++;
      if (acc[i] - acc[i-1] != 5) begin
        mismatched++;
        $display("FAIL b2b_interval[%0d]: got %0d cycles required 5", i, acc[i] - acc[i-1]);
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [15:0] samp;
    int lat;
    int pulses;
    bit ok;
    applyReset();
    runCode(4'h7, samp, lat);
    waitReady(ok);
    bus.inPCM = 4'h5;
    bus.inValid = 1'b1;
    @(posedge clock);
    #1;
    bus.inValid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    compared++;
    if (bus.inReady !== 1'b0 || bus.outValid !== 1'b0 || bus.outSamp !== 16'h0 ||
        bus.outPredictSamp !== 16'h0 || bus.outStepIndex !== 7'd0) begin
      mismatched++;
      $display("FAIL midop_reset: got ready=%b valid=%b samp=%h pred=%h idx=%0d required 0 0 0000 0000 0",
               bus.inReady, bus.outValid, bus.outSamp, bus.outPredictSamp, bus.outStepIndex);
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    mPred = 0;
    mIdx = 0;
    pulses = 0;
    for (int t = 0; t < 12; t++) begin
      @(posedge clock);
      #1;
      if (bus.outValid === 1'b1) pulses++;
    end
    compared++;
    if (pulses != 0) begin
      mismatched++;
      $display("FAIL midop_novalid: got %0d outValid pulses required 0", pulses);
    end
  endtask

  task automatic test_random();
    logic [15:0] samp;
    logic [15:0] e;
    logic [15:0] s;
    logic [3:0]  c;
    int lat;
    applyReset();
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        s = 16'($urandom_range(0, 65535));
        doSeed(s, 7'($urandom_range(0, 100)));
      end
      c = 4'($urandom_range(0, 15));
      e = mDecode(c);
      runCode(c, samp, lat);
      compared++;
      if (samp !== e || bus.outStepIndex !== 7'(mIdx) || bus.outPredictSamp !== mRound(mPred)) begin
        mismatched++;
        $display("FAIL random[%0d] code=%h: got samp=%h idx=%0d pred=%h required %h %0d %h",
                 n, c, samp, bus.outStepIndex, bus.outPredictSamp, e, mIdx, mRound(mPred));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_init_priority();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ima_adpcm_dec.md
Name: ima_adpcm_dec

Overview:
- Downstream consumer of the IMA ADPCM encoder's 4-bit code stream. Reconstructs 16-bit PCM samples.
- Tracks the predictor with the encoder's internal precision: 19-bit signed, 3 fractional bits. For the same code stream, the decoder's predictor matches the encoder's predictor bit-for-bit.
- Multi-cycle sequential dequantizer with a ready/valid input handshake.
- Supports block re-seeding of predictor and step index, as in IMA/WAV block headers.

Parameters:
RST_STEP_INDEX, 0, step index value loaded at reset (legal range 0..88)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
inPCM  in  4  ADPCM code: bit3 = sign, bits2:0 = magnitude
inValid  in  1  inPCM valid
inInit  in  1  re-seed request, qualified by inReady
inInitSamp  in  16  seed predictor sample, signed
inInitIndex  in  7  seed step index
inReady  out  1  decoder can accept a code or a re-seed
outSamp  out  16  reconstructed sample, signed
outValid  out  1  one-cycle pulse when outSamp is updated
outPredictSamp  out  16  current predictor sample (same formula as outSamp)
outStepIndex  out  7  current step index

Behaviour:
- Reset values: inReady=0, outValid=0, outSamp=0, predictor=0, stepIndex=RST_STEP_INDEX, state=IDLE. Reset may arrive mid-operation; the operation is abandoned and no outValid is generated.
- States and transitions: IDLE -> BIT2 -> BIT1 -> BIT0 -> DONE -> IDLE. Unused state encodings go to IDLE.
- inReady is registered:
  - Set to 1 in IDLE when nothing is accepted, and set to 1 in DONE.
  - Cleared on the edge that accepts a code.
- Accept condition (code): state=IDLE and inReady and inValid and !inInit. On acceptance, latch inPCM and go to BIT2.
- Re-seed condition: state=IDLE and inReady and inInit. inInit has priority over inValid in the same cycle.
  - Predictor <= {inInitSamp, 3'b0}.
  - stepIndex <= min(inInitIndex, 88).
  - inReady stays 1; no outValid; the code on inPCM is not consumed.
- stepSize: registered lookup of the standard 89-entry IMA table (7..32767), 15 bits unsigned. Indices above 88 return 32767.
- Dequantization (19-bit unsigned accumulator dq):
  - BIT2: dq <= stepSize + (bit2 ? stepSize<<3 : 0).
  - BIT1: dq += bit1 ? stepSize<<2 : 0.
  - BIT0: dq += bit0 ? stepSize<<1 : 0.
- DONE:
  - Compute pre = sign-extended 20-bit predictor ∓ dq (subtract when bit3=1, add when bit3=0).
  - Saturate pre to 19-bit signed: [-2^18, 2^18-1].
  - Register the saturated value as the new predictor.
  - Update stepIndex: add delta {-1,-1,-1,-1,2,4,6,8} indexed by bits2:0; clamp below at 0 and above at 88.
- Output rounding: outSamp = pred[18:3] + pred[2]. If pred[18:3]=0x7FFF and pred[2]=1, the result saturates to 0x7FFF (no wrap to 0x8000). outPredictSamp uses the same formula, continuously from the current predictor.
- Latency and throughput:
  - Code accepted on edge k; outSamp/outValid are registered on edge k+5.
  - outValid is high for exactly one cycle.
  - Sustained throughput is one code per 5 cycles.
- No backpressure on the output side. The consumer must take outSamp while outValid is high.

Decomposition:
- Shared package ima_adpcm_pkg:
  - State encoding.
  - Widths: sample 16, predictor 19, step 15, index 7.
  - Step-size table constant, index-delta table constant, max index 88.
  - This package is shared with the encoder.
- Sub-module ima_adpcm_step_rom: registered index->stepSize lookup, one cycle, reused by the encoder.

Test Plan:
- Reset, then inPCM=4'h0 -> after 5 cycles outValid pulse; predictor=7; outSamp=0x0001; outStepIndex=0 (clamped at the low bound).
- Reset, then inPCM=4'h7 -> dq=105; outSamp=13 (0x000D); outStepIndex=8. Next code uses stepSize=16.
- Reset, then inPCM=4'hF -> predictor=-105; outSamp=0xFFF3 (-13); outStepIndex=8.
- Re-seed 0x7FFF/idx 88, then code 4'h7 -> predictor saturates to 0x3FFFF; outSamp=0x7FFF; index stays 88. Re-seed 0x8000/idx 88, then code 4'hF -> outSamp=0x8000.
- Handshake cases:
  - inValid held high with a stream of codes -> accepts every 5 cycles, one outValid per code, none dropped.
  - inInit and inValid in the same cycle -> only the seed is applied and the code is still pending.
  - Reset asserted in BIT1 -> all outputs return to reset values and no outValid follows.
- Loopback: random 16-bit samples through encoder then decoder -> decoder outPredictSamp equals encoder outPredictSamp for every sample, except the defined 0x7FFF rounding saturation.
